bounce_emulator: RTL and testbench

//  Synthesizable mechanical-switch emulator: turns a clean level (from a test FSM, UART command or

---
 rtl/bounce_emulator.sv | 101 ++++++++++
 tb/tb_bounce_emulator.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bounce_emulator.sv
// Mechanical-switch emulator: turns a clean level into a bounded burst of LFSR chatter,
// then settles on the new level and pulses 'settled'.
module bounce_emulator #(
  parameter int          BOUNCE_TICKS = 10,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clean_in,
  output logic bouncy_out,
  output logic busy,
  output logic settled
);

  localparam int          CNT_W    = (BOUNCE_TICKS > 2) ? $clog2(BOUNCE_TICKS) : 1;
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BOUNCE_TICKS - 1);

  typedef enum logic {IDLE = 1'b0, BOUNCE = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [15:0]      lfsr, lfsr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             target, target_nxt;
  logic             bouncy_nxt, busy_nxt, settled_nxt;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting left
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lfsr       <= SEED_EFF;
      count      <= '0;
      target     <= 1'b0;
      bouncy_out <= 1'b0;
      busy       <= 1'b0;
      settled    <= 1'b0;
    end else begin
      state      <= state_nxt;
      lfsr       <= lfsr_nxt;
      count      <= count_nxt;
      target     <= target_nxt;
      bouncy_out <= bouncy_nxt;
      busy       <= busy_nxt;
      settled    <= settled_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lfsr_nxt    = lfsr_step(lfsr);
    count_nxt   = count;
    target_nxt  = target;
    bouncy_nxt  = bouncy_out;
    busy_nxt    = busy;
    settled_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!enable) begin
          bouncy_nxt = clean_in;
          target_nxt = clean_in;
        end else if (clean_in != target) begin
          target_nxt = clean_in;
          count_nxt  = '0;
          busy_nxt   = 1'b1;
          state_nxt  = BOUNCE;
        end else begin
          bouncy_nxt = target;
        end
      end
      BOUNCE: begin
        // Priority: abort, then retarget (restarts window), then final count
        if (!enable) begin
          bouncy_nxt = clean_in;
          target_nxt = clean_in;
          count_nxt  = '0;
          busy_nxt   = 1'b0;
          state_nxt  = IDLE;
        end else if (clean_in != target) begin
          target_nxt = clean_in;
          count_nxt  = '0;
          bouncy_nxt = lfsr[0];
        end else if (count == LAST) begin
          bouncy_nxt  = target;
          busy_nxt    = 1'b0;
          settled_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          bouncy_nxt = lfsr[0];
          count_nxt  = count + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bounce_emulator.sv
// Directed bench for bounce_emulator: reset, chatter vs reference LFSR, retarget, pass-through,
// abort, async reset mid-window and a closed loop through a behavioural debouncer.
module tb_bounce_emulator;

  localparam int          BOUNCE_TICKS = 10;
  localparam logic [15:0] SEED         = 16'hACE1;

  logic clk = 1'b0;
  logic rst, enable, clean_in;
  logic bouncy_out, busy, settled;

  int total = 0;
  int bad   = 0;

  bounce_emulator #(.BOUNCE_TICKS(BOUNCE_TICKS), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clean_in(clean_in),
    .bouncy_out(bouncy_out), .busy(busy), .settled(settled)
  );

  always #5 clk = ~clk;

  // Reference LFSR; exp_bit holds the bit the DUT saw before the latest edge
  logic [15:0] m_lfsr = SEED;
  logic        exp_bit = 1'b0;
  always @(posedge clk) begin
    if (!rst) m_lfsr <= SEED;
    else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    exp_bit <= m_lfsr[0];
  end

  // Behavioural debouncer: needs 10 consecutive differing samples to flip
  logic deb = 1'b0;
  int   dcnt = 0;
  int   deb_edges = 0;
  always @(posedge clk) begin
    if (!rst) begin
      deb  <= 1'b0;
      dcnt <= 0;
    end else if (bouncy_out != deb) begin
      if (dcnt == 9) begin
        deb       <= ~deb;
        dcnt      <= 0;
        deb_edges <= deb_edges + 1;
      end else begin
        dcnt <= dcnt + 1;
      end
    end else begin
      dcnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int e0;
  int gap;

  initial begin
    rst = 1'b0; enable = 1'b1; clean_in = 1'b1;
    // Reset state
    repeat (3) tick();
    check("rst_bouncy", 16'(bouncy_out), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_settled", 16'(settled), 16'd0);
    check("rst_lfsr", dut.lfsr, 16'hACE1);
    clean_in = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();

    // Rising edge with full chatter window
    clean_in = 1'b1;
    tick();
    check("rise_busy0", 16'(busy), 16'd1);
    check("rise_hold_old", 16'(bouncy_out), 16'd0);
    for (int k = 1; k < BOUNCE_TICKS; k++) begin
      tick();
      check("rise_chatter", 16'(bouncy_out), 16'(exp_bit));
      check("rise_busy", 16'(busy), 16'd1);
    end
    tick();
    check("rise_final", 16'(bouncy_out), 16'd1);
    check("rise_settled", 16'(settled), 16'd1);
    check("rise_busy_off", 16'(busy), 16'd0);
    tick();
    check("rise_settled_pulse", 16'(settled), 16'd0);
    check("rise_busy_after", 16'(busy), 16'd0);
    check("rise_level_after", 16'(bouncy_out), 16'd1);

    // Retarget: 1->0, back to 1 four cycles later
    clean_in = 1'b0;
    tick();
    repeat (3) tick();
    clean_in = 1'b1;
    tick();
    for (int k = 1; k < BOUNCE_TICKS; k++) begin
      tick();
      check("retgt_busy", 16'(busy), 16'd1);
      check("retgt_no_settle", 16'(settled), 16'd0);
    end
    tick();
    check("retgt_settled", 16'(settled), 16'd1);
    check("retgt_level", 16'(bouncy_out), 16'd1);

    // Pass-through
    enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic drv;
      if (i % 3 == 0) clean_in = ~clean_in;
      drv = clean_in;
      tick();
      check("pass_level", 16'(bouncy_out), 16'(drv));
      check("pass_busy", 16'(busy), 16'd0);
      check("pass_settled", 16'(settled), 16'd0);
    end
    enable = 1'b1;
    tick();
    check("pass_reenable", 16'(busy), 16'd0);

    // Mid-window abort on the 5th BOUNCE cycle
    clean_in = 1'b0;
    tick();
    check("abort_enter", 16'(busy), 16'd1);
    repeat (4) tick();
    enable = 1'b0;
    tick();
    check("abort_level", 16'(bouncy_out), 16'd0);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_settled", 16'(settled), 16'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("abort_no_settle", 16'(settled), 16'd0);
    end
    enable = 1'b1;
    tick();
    check("abort_reenable", 16'(busy), 16'd0);

    // Asynchronous reset in the middle of a window
    clean_in = 1'b1;
    tick();
    tick();
    tick();
    check("arst_pre_busy", 16'(busy), 16'd1);
    rst = 1'b0;
    #1;
    check("arst_busy", 16'(busy), 16'd0);
    check("arst_bouncy", 16'(bouncy_out), 16'd0);
    check("arst_settled", 16'(settled), 16'd0);
    check("arst_lfsr", dut.lfsr, 16'hACE1);
    clean_in = 1'b0;
    tick();
    rst = 1'b1;
    repeat (20) tick();

    // Closed loop through debouncer
    for (int i = 0; i < 20; i++) begin
      e0 = deb_edges;
      clean_in = ~clean_in;
      gap = $urandom_range(60, 40);
      repeat (gap) tick();
      check("loop_level", 16'(deb), 16'(clean_in));
      check("loop_edges", 16'(deb_edges - e0), 16'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
